// File: rtl/dbg_pkg.sv
// Shared definitions for the debug CPU responder.
// Holds the halt FSM state encoding (also reported in STATUS.state), the
// register word indices of the control region, the address region codes,
// the halt cause codes and the value returned for unmapped/illegal reads.
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_RUNNING  = 3'd0,
    ST_HALTING  = 3'd1,
    ST_HALTED   = 3'd2,
    ST_STEPPING = 3'd3
  } dbg_state_e;

  // Word indices inside the control region (dbg_addr_i[7:3])
  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_NPC    = 5'd2;
  localparam logic [4:0] REG_PPC    = 5'd3;
  localparam logic [4:0] REG_CAUSE  = 5'd4;

  // Region codes (dbg_addr_i[15:14])
  localparam logic [1:0] RGN_CSR = 2'b00;
  localparam logic [1:0] RGN_GPR = 2'b01;

  // Halt causes
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_CTRL = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  localparam logic [63:0] DEAD_VALUE = 64'hDEADBEEF;

endpackage

// File: rtl/dbg_halt_fsm.sv
// Halt/step controller for the debug responder.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   halt_i          level halt request from the debugger
//   resume_i        resume request; only its rising edge is used
//   ctrl_halt_i     CTRL.halt as currently stored
//   ctrl_step_i     CTRL.step as currently stored
//   ctrl_halt_wr_i  a CTRL write with halt=1 is being accepted this cycle
//   idle_i          core pipeline drained
//   retire_i        core retired an instruction this cycle
//   state_o         current state
//   cause_o         reason for the most recent halt
//   stall_o         stall the core pipeline
//   halted_o        core is fully halted
module dbg_halt_fsm
  import dbg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt_i,
  input  logic       resume_i,
  input  logic       ctrl_halt_i,
  input  logic       ctrl_step_i,
  input  logic       ctrl_halt_wr_i,
  input  logic       idle_i,
  input  logic       retire_i,
  output dbg_state_e state_o,
  output logic [1:0] cause_o,
  output logic       stall_o,
  output logic       halted_o
);

  dbg_state_e state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       resume_q, resume_d;
  logic       resume_edge;

  assign resume_d    = resume_i;
  assign resume_edge = resume_i & ~resume_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUNNING;
      cause_q  <= CAUSE_NONE;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_RUNNING: begin
        if (halt_i) begin
          state_d = ST_HALTING;
          cause_d = CAUSE_EXT;
        end else if (ctrl_halt_wr_i) begin
          state_d = ST_HALTING;
          cause_d = CAUSE_CTRL;
        end
      end
      ST_HALTING: begin
        if (idle_i) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        // Any active halt source swallows a resume edge.
        if (resume_edge && !halt_i && !ctrl_halt_i) begin
          if (ctrl_step_i) state_d = ST_STEPPING;
          else             state_d = ST_RUNNING;
        end
      end
      ST_STEPPING: begin
        if (retire_i) begin
          state_d = ST_HALTING;
          cause_d = CAUSE_STEP;
        end
      end
      default: state_d = ST_RUNNING;
    endcase
  end

  assign state_o  = state_q;
  assign cause_o  = cause_q;
  assign stall_o  = (state_q == ST_HALTING) || (state_q == ST_HALTED);
  assign halted_o = (state_q == ST_HALTED);

endmodule

// File: rtl/dbg_cpu_responder.sv
// Debug-port responder for a CPU core: decodes single-outstanding debug
// accesses into control registers and core GPRs, and drives halt/step.
// Ports:
//   dbg_req_i/we_i/addr_i/wdata_i   debug access request
//   dbg_gnt_o                       access accepted (combinational)
//   dbg_rvalid_o/rdata_o            response, one cycle after grant
//   dbg_halt_i/resume_i/fetch_i     run control from the debugger
//   dbg_halted_o                    core halted
//   core_stall_o/idle_i/retire_i    pipeline control and status
//   core_pc_i                       PC of retiring instruction
//   core_fetch_en_o                 registered dbg_fetch_i
//   core_npc_o/npc_we_o             next-PC override
//   core_rf_*                       GPR access port into the core
module dbg_cpu_responder
  import dbg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_GPR    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [15:0]           dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  input  logic                  dbg_halt_i,
  input  logic                  dbg_resume_i,
  input  logic                  dbg_fetch_i,
  output logic                  dbg_halted_o,
  output logic                  core_stall_o,
  input  logic                  core_idle_i,
  input  logic                  core_retire_i,
  input  logic [DATA_WIDTH-1:0] core_pc_i,
  output logic                  core_fetch_en_o,
  output logic [DATA_WIDTH-1:0] core_npc_o,
  output logic                  core_npc_we_o,
  output logic                  core_rf_req_o,
  output logic                  core_rf_we_o,
  output logic [4:0]            core_rf_addr_o,
  output logic [DATA_WIDTH-1:0] core_rf_wdata_o,
  input  logic [DATA_WIDTH-1:0] core_rf_rdata_i
);

  localparam logic [DATA_WIDTH-1:0] DEAD = DATA_WIDTH'(DEAD_VALUE);

  dbg_state_e            state;
  logic [1:0]            cause;
  logic                  halted;

  logic                  pending_q, pending_d;
  logic                  gpr_rd_q, gpr_rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] npc_q, npc_d;
  logic                  npc_we_q, npc_we_d;
  logic [DATA_WIDTH-1:0] ppc_q, ppc_d;
  logic                  fetch_q, fetch_d;

  logic                  grant;
  logic [1:0]            region;
  logic [4:0]            widx;
  logic                  gpr_in_range;
  logic                  rf_go;
  logic                  ctrl_halt_wr;
  logic                  unused_addr;

  assign unused_addr  = ^{dbg_addr_i[13:8], dbg_addr_i[2:0]};

  assign region       = dbg_addr_i[15:14];
  assign widx         = dbg_addr_i[7:3];
  assign gpr_in_range = (32'(widx) < NUM_GPR);
  // Gated with rst_n so the grant is forced low while reset is held.
  assign grant        = rst_n & dbg_req_i & ~pending_q;
  assign rf_go        = grant & (region == RGN_GPR) & gpr_in_range & halted;

  assign dbg_gnt_o       = grant;
  assign dbg_rvalid_o    = pending_q;
  assign dbg_rdata_o     = !pending_q ? '0 : (gpr_rd_q ? core_rf_rdata_i : rdata_q);
  assign core_rf_req_o   = rf_go;
  assign core_rf_we_o    = rf_go & dbg_we_i;
  assign core_rf_addr_o  = rf_go ? widx : '0;
  assign core_rf_wdata_o = rf_go ? dbg_wdata_i : '0;
  assign core_npc_o      = npc_q;
  assign core_npc_we_o   = npc_we_q;
  assign core_fetch_en_o = fetch_q;

  dbg_halt_fsm u_halt_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt_i         (dbg_halt_i),
    .resume_i       (dbg_resume_i),
    .ctrl_halt_i    (ctrl_q[0]),
    .ctrl_step_i    (ctrl_q[1]),
    .ctrl_halt_wr_i (ctrl_halt_wr),
    .idle_i         (core_idle_i),
    .retire_i       (core_retire_i),
    .state_o        (state),
    .cause_o        (cause),
    .stall_o        (core_stall_o),
    .halted_o       (halted)
  );

  assign dbg_halted_o = halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      gpr_rd_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      err_q     <= 1'b0;
      npc_q     <= '0;
      npc_we_q  <= 1'b0;
      ppc_q     <= '0;
      fetch_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      gpr_rd_q  <= gpr_rd_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      err_q     <= err_d;
      npc_q     <= npc_d;
      npc_we_q  <= npc_we_d;
      ppc_q     <= ppc_d;
      fetch_q   <= fetch_d;
    end
  end

  always_comb begin
    pending_d    = grant;
    gpr_rd_d     = 1'b0;
    rdata_d      = '0;
    ctrl_d       = ctrl_q;
    err_d        = err_q;
    npc_d        = npc_q;
    npc_we_d     = 1'b0;
    ppc_d        = core_retire_i ? core_pc_i : ppc_q;
    fetch_d      = dbg_fetch_i;
    ctrl_halt_wr = 1'b0;

    if (grant) begin
      rdata_d = DEAD;
      unique case (region)
        RGN_CSR: begin
          case (widx)
            REG_CTRL: begin
              rdata_d = DATA_WIDTH'(ctrl_q);
              if (dbg_we_i) begin
                ctrl_d       = dbg_wdata_i[1:0];
                err_d        = 1'b0;
                ctrl_halt_wr = dbg_wdata_i[0];
              end
            end
            // State is sampled here, before this edge's transition.
            REG_STATUS: rdata_d = DATA_WIDTH'({err_q, cause, state});
            REG_NPC: begin
              rdata_d = npc_q;
              if (dbg_we_i) begin
                if (halted) begin
                  npc_d    = dbg_wdata_i;
                  npc_we_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
            end
            REG_PPC:   rdata_d = ppc_q;
            REG_CAUSE: rdata_d = DATA_WIDTH'(cause);
            default:   rdata_d = DEAD;
          endcase
        end
        RGN_GPR: begin
          if (!halted)                         err_d    = 1'b1;
          else if (gpr_in_range && !dbg_we_i) gpr_rd_d = 1'b1;
        end
        default: rdata_d = DEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_cpu_responder.sv
module tb_dbg_cpu_responder;
  import dbg_pkg::*;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dbg_req_i = 1'b0;
  logic          dbg_we_i = 1'b0;
  logic [15:0]   dbg_addr_i = '0;
  logic [DW-1:0] dbg_wdata_i = '0;
  logic          dbg_gnt_o;
  logic          dbg_rvalid_o;
  logic [DW-1:0] dbg_rdata_o;
  logic          dbg_halt_i = 1'b0;
  logic          dbg_resume_i = 1'b0;
  logic          dbg_fetch_i = 1'b0;
  logic          dbg_halted_o;
  logic          core_stall_o;
  logic          core_idle_i = 1'b0;
  logic          core_retire_i = 1'b0;
  logic [DW-1:0] core_pc_i = '0;
  logic          core_fetch_en_o;
  logic [DW-1:0] core_npc_o;
  logic          core_npc_we_o;
  logic          core_rf_req_o;
  logic          core_rf_we_o;
  logic [4:0]    core_rf_addr_o;
  logic [DW-1:0] core_rf_wdata_o;
  logic [DW-1:0] core_rf_rdata_i;

  always #5 clk = ~clk;

  dbg_cpu_responder #(.DATA_WIDTH(DW), .NUM_GPR(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
    .dbg_rdata_o(dbg_rdata_o), .dbg_halt_i(dbg_halt_i), .dbg_resume_i(dbg_resume_i),
    .dbg_fetch_i(dbg_fetch_i), .dbg_halted_o(dbg_halted_o), .core_stall_o(core_stall_o),
    .core_idle_i(core_idle_i), .core_retire_i(core_retire_i), .core_pc_i(core_pc_i),
    .core_fetch_en_o(core_fetch_en_o), .core_npc_o(core_npc_o), .core_npc_we_o(core_npc_we_o),
    .core_rf_req_o(core_rf_req_o), .core_rf_we_o(core_rf_we_o), .core_rf_addr_o(core_rf_addr_o),
    .core_rf_wdata_o(core_rf_wdata_o), .core_rf_rdata_i(core_rf_rdata_i)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Core register file stand-in: requests are captured away from the edge,
  // then serviced at the edge; read data appears one cycle later.
  logic [DW-1:0] core_mem [32] = '{default: '0};
  logic          m_req, m_we;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_wd;
  always @(negedge clk) begin
    m_req  <= core_rf_req_o;
    m_we   <= core_rf_we_o;
    m_addr <= core_rf_addr_o;
    m_wd   <= core_rf_wdata_o;
  end
  always @(posedge clk) begin
    core_rf_rdata_i <= {$urandom, $urandom};
    if (m_req) begin
      if (m_we) core_mem[m_addr] <= m_wd;
      else      core_rf_rdata_i  <= core_mem[m_addr];
    end
  end

  // Reference model of the debug-visible behaviour
  typedef struct {
    logic          is_wr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] ref_gpr [32] = '{default: '0};
  dbg_state_e    m_state;
  logic [1:0]    m_cause, m_ctrl;
  logic          m_err, m_pending, m_npc_we, m_fetch, m_res_prev;
  logic [DW-1:0] m_npc, m_ppc;

  task automatic model_reset();
    m_state = ST_RUNNING; m_cause = '0; m_ctrl = '0; m_err = 1'b0;
    m_pending = 1'b0; m_npc_we = 1'b0; m_fetch = 1'b0; m_res_prev = 1'b0;
    m_npc = '0; m_ppc = '0;
    sb.delete();
  endtask

  // Advance the model by one clock using the inputs held over the last cycle.
  task automatic model_tick();
    logic acc, hlt, hwr, old_res;
    logic [1:0] rg, old_ctrl;
    logic [4:0] wi;
    logic [DW-1:0] e;
    acc = dbg_req_i && !m_pending;
    rg = dbg_addr_i[15:14];
    wi = dbg_addr_i[7:3];
    hlt = (m_state == ST_HALTED);
    hwr = 1'b0;
    old_ctrl = m_ctrl;
    old_res = m_res_prev;
    m_npc_we = 1'b0;
    if (acc) begin
      e = 64'hDEADBEEF;
      if (rg == 2'b00) begin
        case (wi)
          5'd0: e = {62'b0, m_ctrl};
          5'd1: e = {58'b0, m_err, m_cause, m_state};
          5'd2: e = m_npc;
          5'd3: e = m_ppc;
          5'd4: e = {62'b0, m_cause};
          default: e = 64'hDEADBEEF;
        endcase
        if (dbg_we_i && wi == 5'd0) begin
          m_ctrl = dbg_wdata_i[1:0];
          m_err = 1'b0;
          hwr = dbg_wdata_i[0];
        end
        if (dbg_we_i && wi == 5'd2) begin
          if (hlt) begin m_npc = dbg_wdata_i; m_npc_we = 1'b1; end
          else m_err = 1'b1;
        end
      end else if (rg == 2'b01) begin
        if (hlt) begin
          e = ref_gpr[wi];
          if (dbg_we_i) ref_gpr[wi] = dbg_wdata_i;
        end else begin
          m_err = 1'b1;
        end
      end
      sb.push_back('{is_wr: dbg_we_i, data: e});
    end
    case (m_state)
      ST_RUNNING:
        if (dbg_halt_i) begin m_state = ST_HALTING; m_cause = 2'd1; end
        else if (hwr) begin m_state = ST_HALTING; m_cause = 2'd2; end
      ST_HALTING:
        if (core_idle_i) m_state = ST_HALTED;
      ST_HALTED:
        if (dbg_resume_i && !old_res && !dbg_halt_i && !old_ctrl[0]) begin
          if (old_ctrl[1]) m_state = ST_STEPPING;
          else             m_state = ST_RUNNING;
        end
      ST_STEPPING:
        if (core_retire_i) begin m_state = ST_HALTING; m_cause = 2'd3; end
      default: ;
    endcase
    if (core_retire_i) m_ppc = core_pc_i;
    m_pending = acc;
    m_fetch = dbg_fetch_i;
    m_res_prev = dbg_resume_i;
  endtask

  // Monitor: compares DUT outputs against the model between clock edges.
  logic gnt_prev = 1'b0;
  always @(negedge clk) begin
    logic rf_exp;
    exp_t ex;
    if (!rst_n) begin
      chk("rst_rvalid", 64'(dbg_rvalid_o), 0);
      chk("rst_gnt", 64'(dbg_gnt_o), 0);
      chk("rst_stall", 64'(core_stall_o), 0);
      chk("rst_halted", 64'(dbg_halted_o), 0);
      chk("rst_ctl_outs", 64'({core_npc_we_o, core_rf_req_o, core_rf_we_o, core_fetch_en_o}), 0);
      chk("rst_npc", core_npc_o, 0);
      chk("rst_rdata", dbg_rdata_o, 0);
      gnt_prev = 1'b0;
    end else begin
      chk("gnt", 64'(dbg_gnt_o), 64'(dbg_req_i && !m_pending));
      chk("rvalid_timing", 64'(dbg_rvalid_o), 64'(gnt_prev));
      gnt_prev = dbg_gnt_o;
      if (dbg_rvalid_o) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", 64'(dbg_rvalid_o), 0);
        end else begin
          ex = sb.pop_front();
          if (!ex.is_wr) chk("rdata", dbg_rdata_o, ex.data);
        end
      end
      chk("stall", 64'(core_stall_o), 64'(m_state == ST_HALTING || m_state == ST_HALTED));
      chk("halted", 64'(dbg_halted_o), 64'(m_state == ST_HALTED));
      rf_exp = dbg_req_i && !m_pending && dbg_addr_i[15:14] == 2'b01 && m_state == ST_HALTED;
      chk("rf_req", 64'(core_rf_req_o), 64'(rf_exp));
      if (rf_exp) begin
        chk("rf_addr", 64'(core_rf_addr_o), 64'(dbg_addr_i[7:3]));
        chk("rf_we", 64'(core_rf_we_o), 64'(dbg_we_i));
        if (dbg_we_i) chk("rf_wdata", core_rf_wdata_o, dbg_wdata_i);
      end
      chk("npc_we", 64'(core_npc_we_o), 64'(m_npc_we));
      chk("npc", core_npc_o, m_npc);
      chk("fetch_en", 64'(core_fetch_en_o), 64'(m_fetch));
    end
  end

  // Stimulus
  bit r_ok = 1'b1;

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_tick();
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      dbg_fetch_i = 1'($urandom_range(0, 1));
      if (r_ok) begin
        core_retire_i = 1'($urandom_range(0, 1));
        core_pc_i = {$urandom, $urandom};
      end
      cycle();
    end
  endtask

  function automatic logic [15:0] csr(input int unsigned idx);
    logic [4:0] i5;
    i5 = 5'(idx);
    return {2'b00, 6'b0, i5, 3'b0};
  endfunction

  task automatic access(input logic we, input logic [15:0] addr, input logic [DW-1:0] wd);
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
    step(1);
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_wdata_i = {$urandom, $urandom};
    step(1);
  endtask

  // Random access that never writes CTRL, so the run-control phases stay directed.
  task automatic rand_access(input bit gpr_bias);
    logic [1:0] rg;
    logic [4:0] idx;
    logic we;
    rg  = gpr_bias ? ($urandom_range(0, 3) == 0 ? 2'b00 : 2'b01) : 2'($urandom_range(0, 3));
    idx = (rg == 2'b01) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    we  = 1'($urandom_range(0, 1));
    if (rg == 2'b00 && idx == 5'd0) we = 1'b0;
    access(we, {rg, 6'($urandom), idx, 3'($urandom)}, {$urandom, $urandom});
    step($urandom_range(0, 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Running: mixed register and unmapped accesses
    for (int i = 0; i < 30; i++) rand_access(1'b0);

    // GPR read while running, then err is cleared by a CTRL write
    access(1'b0, 16'h4008, '0);
    access(1'b0, csr(1), '0);
    access(1'b1, csr(0), 64'h0);
    access(1'b0, csr(1), '0);

    // External halt with a slow drain
    core_idle_i = 1'b0; dbg_halt_i = 1'b1;
    step(3);
    core_idle_i = 1'b1;
    step(1);
    access(1'b0, csr(1), '0);
    access(1'b0, csr(4), '0);

    // GPR round trip while halted
    access(1'b1, 16'h4028, 64'h1234_5678_9ABC_DEF0);
    access(1'b0, 16'h4028, '0);
    for (int i = 0; i < 25; i++) rand_access(1'b1);
    access(1'b1, csr(2), {$urandom, $urandom});
    access(1'b0, csr(2), '0);

    // Resume edge while the halt request is still asserted is ignored
    dbg_resume_i = 1'b1; step(2);
    dbg_resume_i = 1'b0; step(1);
    access(1'b0, csr(1), '0);
    dbg_halt_i = 1'b0; step(1);
    dbg_resume_i = 1'b1; step(2);
    dbg_resume_i = 1'b0;
    access(1'b0, csr(1), '0);

    // NPC write while running sets err without a load pulse
    access(1'b1, csr(2), {$urandom, $urandom});
    access(1'b0, csr(1), '0);

    // Halt via CTRL.halt
    core_idle_i = 1'b0;
    access(1'b1, csr(0), 64'h1);
    step(2);
    core_idle_i = 1'b1; step(1);
    access(1'b0, csr(4), '0);
    access(1'b0, csr(1), '0);

    // Single step
    access(1'b1, csr(0), 64'h2);
    r_ok = 1'b0; core_retire_i = 1'b0; core_idle_i = 1'b0;
    dbg_resume_i = 1'b1; step(1);
    dbg_resume_i = 1'b0; step(2);
    core_retire_i = 1'b1; core_pc_i = 64'h8000_0010; step(1);
    core_retire_i = 1'b0; core_pc_i = '0;
    access(1'b0, csr(3), '0);
    access(1'b0, csr(4), '0);
    access(1'b0, csr(1), '0);
    core_idle_i = 1'b1; step(1);
    access(1'b0, csr(1), '0);

    // Reset while halted with a read outstanding
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = csr(1);
    step(1);
    dbg_req_i = 1'b0; core_idle_i = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("stall_async_release", 64'(core_stall_o), 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) access(1'b0, csr(i), '0);

    r_ok = 1'b1;
    for (int i = 0; i < 10; i++) rand_access(1'b0);
    step(3);
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dbg_cpu_responder.md
DBG_CPU_RESPONDER -- requirements
Module: dbg_cpu_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, debug data bus width.
REQ-002 SHALL have parameter NUM_GPR, default 32, number of core GPRs reachable through the debug port.
REQ-003 SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-004 Port list; each line gives name, direction, width, meaning.
- clk  in  1  sole clock.
- rst_n  in  1  async active-low reset.
- dbg_req_i  in  1  access request.
- dbg_we_i  in  1  1 = write.
- dbg_addr_i  in  16  byte address.
- dbg_wdata_i  in  DATA_WIDTH  write data.
- dbg_gnt_o  out  1  request accepted.
- dbg_rvalid_o  out  1  response valid.
- dbg_rdata_o  out  DATA_WIDTH  read data.
- dbg_halt_i  in  1  level halt request.
- dbg_resume_i  in  1  resume; rising edge is significant.
- dbg_fetch_i  in  1  fetch enable.
- dbg_halted_o  out  1  core halted.
- core_stall_o  out  1  stall core pipeline.
- core_idle_i  in  1  pipeline drained.
- core_retire_i  in  1  instruction retired this cycle.
- core_pc_i  in  DATA_WIDTH  PC of retiring instruction.
- core_fetch_en_o  out  1  registered dbg_fetch_i.
- core_npc_o  out  DATA_WIDTH  next-PC override value.
- core_npc_we_o  out  1  one-cycle NPC load pulse.
- core_rf_req_o  out  1  GPR access.
- core_rf_we_o  out  1  GPR write.
- core_rf_addr_o  out  5  GPR index.
- core_rf_wdata_o  out  DATA_WIDTH  GPR write data.
- core_rf_rdata_i  in  DATA_WIDTH  GPR read data, one cycle after core_rf_req_o.

Function
REQ-005 dbg_gnt_o SHALL be combinational: dbg_gnt_o = dbg_req_i && !pending; at most one access outstanding.
REQ-006 dbg_rvalid_o SHALL pulse exactly one cycle after each grant, for reads and writes; dbg_rdata_o is valid only while dbg_rvalid_o = 1.
REQ-007 The address map SHALL be decoded on dbg_addr_i[15:14]; the word index is dbg_addr_i[7:3].
- 2'b00 registers: 0 CTRL (bit0 halt, bit1 step), RW; 1 STATUS {err, cause[1:0], state[2:0]}, RO; 2 NPC, RW; 3 PPC, RO; 4 CAUSE, RO.
- 2'b01: GPR index = dbg_addr_i[7:3].
- Otherwise: reads SHALL return 64'hDEADBEEF and writes SHALL be dropped.
REQ-008 A GPR access while halted SHALL assert core_rf_req_o for exactly the grant cycle, and dbg_rdata_o SHALL equal core_rf_rdata_i on the rvalid cycle.
REQ-009 A GPR access while not halted SHALL still be granted, SHALL NOT assert core_rf_req_o, SHALL return 64'hDEADBEEF, and SHALL set sticky STATUS.err; err is cleared only by writing CTRL.
REQ-010 A write to NPC while halted SHALL update core_npc_o and pulse core_npc_we_o on the following cycle; an NPC write while not halted SHALL set err and SHALL NOT pulse.
REQ-011 PPC SHALL capture core_pc_i on every cycle with core_retire_i = 1.
REQ-012 Halt FSM states SHALL be RUNNING, HALTING, HALTED, STEPPING, with these transitions.
- RUNNING -> HALTING on dbg_halt_i = 1 (cause = 1) or on a CTRL.halt write of 1 (cause = 2).
- HALTING -> HALTED on core_idle_i = 1.
- HALTED -> RUNNING on a dbg_resume_i rising edge with CTRL.step = 0 and dbg_halt_i = 0 and CTRL.halt = 0.
- HALTED -> STEPPING on a resume edge with CTRL.step = 1.
- STEPPING -> HALTING on the first core_retire_i (cause = 3).
REQ-013 core_stall_o SHALL be 1 in HALTING and HALTED, and 0 in RUNNING and STEPPING.
REQ-014 dbg_halted_o SHALL be 1 only in HALTED.
REQ-015 A resume edge coincident with an active halt source in HALTED SHALL be ignored; halt wins.
REQ-016 A STATUS read SHALL return the state registered at grant, i.e. the pre-transition value.
REQ-017 core_fetch_en_o SHALL be dbg_fetch_i delayed one register stage.

Reset
REQ-018 On rst_n low, asynchronously, the following SHALL be forced:
- State = RUNNING.
- All outputs 0.
- CTRL, NPC, PPC, CAUSE and err = 0.
- pending = 0.
- The resume edge detector history = 0.
REQ-019 A reset asserted during HALTING, HALTED or STEPPING SHALL release core_stall_o immediately and SHALL discard any outstanding response.

Structure
REQ-020 Package dbg_pkg SHALL hold the FSM state enum, the register word indices, the region codes, the cause codes and the 64'hDEADBEEF constant.
REQ-021 The halt FSM, including resume edge detection and cause tracking, SHALL be a sub-module named dbg_halt_fsm; decode and response logic SHALL live in the top module.

Verification
REQ-022 Halt: dbg_halt_i = 1 with core_idle_i = 0 for 3 cycles, then 1 -> core_stall_o = 1 from the first cycle; dbg_halted_o = 1 on the cycle after idle; STATUS.cause = 1.
REQ-023 GPR round trip while halted: write 0x1234_5678_9ABC_DEF0 to address 0x4028, then read the same address -> core_rf_addr_o = 5 on both accesses; read rvalid returns the model value; each rvalid arrives 1 cycle after gnt.
REQ-024 GPR read while running at address 0x4008 -> rdata = 64'hDEADBEEF; core_rf_req_o stays 0; STATUS.err = 1 until the next CTRL write.
REQ-025 Single step: CTRL = 2'b10, resume edge, core_retire_i pulse with core_pc_i = 0x8000_0010 -> STEPPING, then HALTING; PPC = 0x8000_0010; cause = 3.
REQ-026 Resume edge while dbg_halt_i = 1 in HALTED -> remains HALTED; core_stall_o = 1.
REQ-027 rst_n asserted in HALTED with a read outstanding -> no rvalid; core_stall_o = 0 immediately; after release, state = RUNNING and all registers = 0.
